// File: rtl/branch_target_unit_if.sv
// Bundle between the ID-stage target generator and its neighbours: instruction
// capture controls on the way in, registered target/link/RAS prediction on the way out.
interface branch_target_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            stall;
    logic            flush;
    logic [31:0]     inst_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_data;
    logic            out_valid;
    logic [1:0]      kind;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;
    logic [XLEN-1:0] ras_pred;
    logic            ras_hit;

    modport master (
        output in_valid, stall, flush, inst_in, pc_in, rs1_data,
        input  out_valid, kind, target, link_addr, ras_pred, ras_hit
    );

    modport slave (
        input  in_valid, stall, flush, inst_in, pc_in, rs1_data,
        output out_valid, kind, target, link_addr, ras_pred, ras_hit
    );
endinterface

// File: rtl/branch_target_unit.sv
// ID-stage branch/JAL/JALR target and link generator with a circular return-address
// stack; one registered stage that honours stall and flush.
module branch_target_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    branch_target_unit_if.slave bus
);
    localparam int STAGES = 1;
    localparam int PW     = $clog2(RAS_DEPTH);
    localparam int CW     = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] K_NONE   = 2'b00;
    localparam logic [1:0] K_BRANCH = 2'b01;
    localparam logic [1:0] K_JAL    = 2'b10;
    localparam logic [1:0] K_JALR   = 2'b11;

    typedef struct packed {
        logic [1:0]      kind;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic [XLEN-1:0] pred;
        logic            hit;
    } rsp_t;

    logic [31:0]     inst;
    logic [4:0]      rd, rs1;
    logic [XLEN-1:0] imm_b, imm_j, imm_i, four;
    logic            is_br, is_jal, is_jalr;
    logic            link_rd, link_rs1, do_push, do_pop, pop_ok, accept;
    logic [PW-1:0]   ras_ptr, top_idx;
    logic [CW-1:0]   ras_cnt;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [STAGES:0] vld_pipe;
    rsp_t            rsp_d, rsp_q;

    assign inst    = bus.inst_in;
    assign rd      = inst[11:7];
    assign rs1     = inst[19:15];
    assign is_br   = inst[6:0] == 7'b1100011;
    assign is_jal  = inst[6:0] == 7'b1101111;
    assign is_jalr = inst[6:0] == 7'b1100111;
    assign imm_b   = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j   = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_i   = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign four    = {{(XLEN-3){1'b0}}, 3'd4};

    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign accept   = bus.in_valid & ~bus.stall & ~bus.flush;
    assign top_idx  = ras_ptr - 1'b1;
    assign pop_ok   = do_pop && (ras_cnt != '0);
    assign vld_pipe[0] = accept;

    // Link-register hint table; a matching rd/rs1 pair on JALR is a plain push.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (is_jal) begin
            do_push = link_rd;
        end else if (is_jalr) begin
            do_push = link_rd;
            do_pop  = link_rs1 && (!link_rd || rd != rs1);
        end
    end

    always_comb begin
        rsp_d      = '0;
        rsp_d.link = bus.pc_in + four;
        rsp_d.hit  = pop_ok;
        rsp_d.pred = pop_ok ? ras_mem[top_idx] : '0;
        if (is_br) begin
            rsp_d.kind   = K_BRANCH;
            rsp_d.target = bus.pc_in + imm_b;
        end else if (is_jal) begin
            rsp_d.kind   = K_JAL;
            rsp_d.target = bus.pc_in + imm_j;
        end else if (is_jalr) begin
            rsp_d.kind   = K_JALR;
            rsp_d.target = (bus.rs1_data + imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            rsp_d.kind   = K_NONE;
            rsp_d.target = bus.pc_in + four;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES] <= 1'b0;
            rsp_q            <= '0;
        end else if (bus.flush) begin
            vld_pipe[STAGES] <= 1'b0;
            rsp_q.hit        <= 1'b0;
            rsp_q.kind       <= K_NONE;
        end else if (!bus.stall) begin
            vld_pipe[STAGES] <= vld_pipe[0];
            if (bus.in_valid) rsp_q <= rsp_d;
            else              rsp_q.hit <= 1'b0;
        end
    end

    // Pop-then-push on a live stack rewrites the top in place; on an empty one it is a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (accept) begin
            if (do_push && !pop_ok) begin
                ras_ptr <= ras_ptr + 1'b1;
                if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
            end else if (pop_ok && !do_push) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && do_push) ras_mem[pop_ok ? top_idx : ras_ptr] <= rsp_d.link;
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.kind      = rsp_q.kind;
    assign bus.target    = rsp_q.target;
    assign bus.link_addr = rsp_q.link;
    assign bus.ras_pred  = rsp_q.pred;
    assign bus.ras_hit   = rsp_q.hit;
endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench: expected responses are queued at issue time and a negedge
// monitor pops one per valid output cycle.
module tb_branch_target_unit;
    logic clk, rst_n;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] pred;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;

    localparam logic [31:0] JAL_X1  = 32'h001000EF;
    localparam logic [31:0] JAL_X0  = 32'h0010006F;
    localparam logic [31:0] RET     = 32'h00008067;
    localparam logic [31:0] JALR_15 = 32'h000280E7;
    localparam logic [31:0] BEQ     = 32'hFE000CE3;
    localparam logic [31:0] ADDI    = 32'h00000013;

    branch_target_unit_if #(.XLEN(32)) bus ();

    branch_target_unit #(.XLEN(32), .RAS_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic put(input logic v, input logic st, input logic fl,
                       input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1);
        bus.in_valid = v;
        bus.stall    = st;
        bus.flush    = fl;
        bus.inst_in  = inst;
        bus.pc_in    = pc;
        bus.rs1_data = rs1;
    endtask

    task automatic acc(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [1:0] k, input logic [31:0] tgt,
                       input logic [31:0] pred, input logic hit);
        exp_t e;
        e.kind = k; e.target = tgt; e.link = pc + 32'd4; e.pred = pred; e.hit = hit;
        put(1'b1, 1'b0, 1'b0, inst, pc, rs1);
        exp_q.push_back(e);
        last = e;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got kind=%0d target=%h with nothing expected",
                         bus.kind, bus.target);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.kind !== e.kind || bus.target !== e.target || bus.link_addr !== e.link ||
                    bus.ras_pred !== e.pred || bus.ras_hit !== e.hit) begin
                    bad++;
                    $display("FAIL rsp: got k=%0d t=%h l=%h p=%h h=%b want k=%0d t=%h l=%h p=%h h=%b",
                             bus.kind, bus.target, bus.link_addr, bus.ras_pred, bus.ras_hit,
                             e.kind, e.target, e.link, e.pred, e.hit);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        put(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_kind",   {30'd0, bus.kind}, 32'd0);
        chk("rst_target", bus.target, 32'd0);
        chk("rst_link",   bus.link_addr, 32'd0);
        chk("rst_pred",   bus.ras_pred, 32'd0);
        chk("rst_hit",    {31'd0, bus.ras_hit}, 32'd0);
        rst_n = 1'b1;

        // basic decode, wraparound target, call and return
        @(negedge clk); acc(BEQ,    32'h100,      32'h0,    2'b01, 32'hF8,   32'h0, 1'b0);
        @(negedge clk); acc(ADDI,   32'h200,      32'h0,    2'b00, 32'h204,  32'h0, 1'b0);
        @(negedge clk); acc(JAL_X0, 32'hFFFFFFF0, 32'h0,    2'b10, 32'h7F0,  32'h0, 1'b0);
        @(negedge clk); acc(JAL_X1, 32'h1000,     32'h0,    2'b10, 32'h1800, 32'h0, 1'b0);
        @(negedge clk); acc(RET,    32'h1800,     32'h1005, 2'b11, 32'h1004, 32'h1004, 1'b1);

        // five calls into a four-deep stack, then five returns
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc(JAL_X1, 32'(i * 16), 32'h0, 2'b10, 32'(i * 16) + 32'h800, 32'h0, 1'b0);
        end
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h44, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h34, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h24, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h14, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h0,  1'b0);

        // pop-then-push on empty and non-empty stacks
        @(negedge clk); acc(JALR_15, 32'h500, 32'h601, 2'b11, 32'h600,  32'h0,   1'b0);
        @(negedge clk); acc(JAL_X1,  32'h700, 32'h0,   2'b10, 32'hF00,  32'h0,   1'b0);
        @(negedge clk); acc(JALR_15, 32'h800, 32'h900, 2'b11, 32'h900,  32'h704, 1'b1);

        // stall: outputs hold for three cycles, then the JAL is taken
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            put(1'b1, 1'b1, 1'b0, JAL_X1, 32'h900, 32'h0);
            exp_q.push_back(last);
        end
        @(negedge clk); acc(JAL_X1, 32'h900, 32'h0, 2'b10, 32'h1100, 32'h0, 1'b0);

        // stall+flush behaves as flush
        @(negedge clk); put(1'b1, 1'b1, 1'b1, JAL_X1, 32'hB00, 32'h0);
        @(negedge clk);
        chk("stflush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stflush_kind",  {30'd0, bus.kind}, 32'd0);
        acc(ADDI, 32'hE00, 32'h0, 2'b00, 32'hE04, 32'h0, 1'b0);
        @(negedge clk); put(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
        put(1'b1, 1'b0, 1'b1, JAL_X1, 32'hA00, 32'h0);
        @(negedge clk);
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_hit",   {31'd0, bus.ras_hit}, 32'd0);
        // stack must still be [504, 804, 904]
        acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h904, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h804, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h504, 1'b1);
        @(negedge clk); acc(RET, 32'h2000, 32'h3000, 2'b11, 32'h3000, 32'h0,   1'b0);

        // asynchronous reset mid-cycle after two pushes
        @(negedge clk); acc(JAL_X1, 32'hC00, 32'h0, 2'b10, 32'h1400, 32'h0, 1'b0);
        @(negedge clk); acc(JAL_X1, 32'hD00, 32'h0, 2'b10, 32'h1500, 32'h0, 1'b0);
        @(negedge clk); put(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("arst_kind",   {30'd0, bus.kind}, 32'd0);
        chk("arst_target", bus.target, 32'd0);
        chk("arst_link",   bus.link_addr, 32'd0);
        chk("arst_pred",   bus.ras_pred, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk); acc(RET, 32'hF00, 32'h1234, 2'b11, 32'h1234, 32'h0, 1'b0);
        @(negedge clk); put(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
